// File: rtl/fpu_div_seq.sv
// fpu_div_seq: sequential binary32 divider (restoring quotient loop + RNE) with valid/ready handshakes.
// Optional macro FPU_DIV_DENORM_EN enables denormal input normalization and gradual underflow.

module fpu_div_split (
  input  logic [31:0] f,
  output logic        sign,
  output logic [7:0]  exp,
  output logic [23:0] man,
  output logic        is_zero,
  output logic        is_sub,
  output logic        is_inf,
  output logic        is_nan,
  output logic        is_snan
);
  always_comb begin
    sign    = f[31];
    exp     = f[30:23];
    man     = {(f[30:23] != 8'd0), f[22:0]};
    is_zero = (f[30:23] == 8'd0)  && (f[22:0] == 23'd0);
    is_sub  = (f[30:23] == 8'd0)  && (f[22:0] != 23'd0);
    is_inf  = (f[30:23] == 8'hFF) && (f[22:0] == 23'd0);
    is_nan  = (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
    is_snan = is_nan && !f[22];
  end
endmodule

module fpu_div_seq #(
  parameter logic [31:0] CANON_NAN = 32'h7FC00000,
  parameter int          QBITS     = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [31:0] float_out,
  output logic [4:0]  fflags
);
  localparam logic [4:0] FL_NV = 5'b10000;
  localparam logic [4:0] FL_DZ = 5'b01000;
  localparam logic [4:0] FL_OF = 5'b00100;
  localparam logic [4:0] FL_UF = 5'b00010;
  localparam logic [4:0] FL_NX = 5'b00001;

  typedef enum logic [2:0] {IDLE, SPECIAL, PRE, ITER, ROUND, DONE} state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  e_q, e_d;
  logic [23:0]        ma_q, ma_d, mb_q, mb_d;
  logic [25:0]        rem_q, rem_d, quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        spec_res_q, spec_res_d;
  logic [4:0]         spec_fl_q, spec_fl_d;
  logic               valid_q, valid_d;
  logic [31:0]        res_q, res_d;
  logic [4:0]         flags_q, flags_d;

  logic        a_sign, a_zero, a_sub, a_inf, a_nan, a_snan;
  logic        b_sign, b_zero, b_sub, b_inf, b_nan, b_snan;
  logic [7:0]  a_exp, b_exp, ea_eff, eb_eff;
  logic [23:0] a_man, b_man;
  logic        a_zero_eff, b_zero_eff, sgn;
  logic        spec_hit;
  logic [31:0] spec_val;
  logic [4:0]  spec_fl;

  fpu_div_split u_split_a (
    .f(a), .sign(a_sign), .exp(a_exp), .man(a_man), .is_zero(a_zero),
    .is_sub(a_sub), .is_inf(a_inf), .is_nan(a_nan), .is_snan(a_snan)
  );

  fpu_div_split u_split_b (
    .f(b), .sign(b_sign), .exp(b_exp), .man(b_man), .is_zero(b_zero),
    .is_sub(b_sub), .is_inf(b_inf), .is_nan(b_nan), .is_snan(b_snan)
  );

  assign ready_out = (state_q == IDLE) && !reset;
  assign valid_out = valid_q;
  assign float_out = res_q;
  assign fflags    = flags_q;

  // Without denormal support a subnormal operand behaves exactly like a signed zero.
  always_comb begin
`ifdef FPU_DIV_DENORM_EN
    a_zero_eff = a_zero;
    b_zero_eff = b_zero;
    ea_eff     = (a_exp == 8'd0) ? 8'd1 : a_exp;
    eb_eff     = (b_exp == 8'd0) ? 8'd1 : b_exp;
`else
    a_zero_eff = a_zero | a_sub;
    b_zero_eff = b_zero | b_sub;
    ea_eff     = a_exp;
    eb_eff     = b_exp;
`endif
    sgn      = a_sign ^ b_sign;
    spec_hit = 1'b1;
    spec_val = CANON_NAN;
    spec_fl  = 5'b00000;
    if (a_snan || b_snan) begin
      spec_fl = FL_NV;
    end else if (a_nan || b_nan) begin
      spec_fl = 5'b00000;
    end else if ((a_inf && b_inf) || (a_zero_eff && b_zero_eff)) begin
      spec_fl = FL_NV;
    end else if (b_zero_eff) begin
      spec_val = {sgn, 8'hFF, 23'd0};
      spec_fl  = FL_DZ;
    end else if (a_inf) begin
      spec_val = {sgn, 8'hFF, 23'd0};
    end else if (b_inf || a_zero_eff) begin
      spec_val = {sgn, 31'd0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic        sticky, up, inexact;
  logic [30:0] sum;
  logic [31:0] rnd_res;
  logic [4:0]  rnd_flags;
`ifdef FPU_DIV_DENORM_EN
  logic signed [9:0] shs;
  logic [4:0]        shamt;
  logic [51:0]       shext;
  logic [25:0]       dsig;
  logic              dst;
`endif

  // Quotient is 1.xxx in quo_q[25:2]; adding the significand onto (e-1) lets carries ripple into the exponent.
  always_comb begin
    sticky    = |rem_q;
    up        = quo_q[1] & (quo_q[0] | sticky | quo_q[2]);
    inexact   = quo_q[1] | quo_q[0] | sticky;
    sum       = {e_q[7:0] - 8'd1, 23'd0} + {7'd0, quo_q[25:2]} + 31'(up);
    rnd_res   = {sign_q, sum};
    rnd_flags = {4'b0000, inexact};
`ifdef FPU_DIV_DENORM_EN
    shs   = 10'sd1 - e_q;
    shamt = (shs > 10'sd27) ? 5'd27 : shs[4:0];
    shext = {quo_q, 26'd0} >> shamt;
    dsig  = shext[51:26];
    dst   = sticky | (|shext[25:0]);
`endif
    if (e_q >= 10'sd255) begin
      rnd_res   = {sign_q, 8'hFF, 23'd0};
      rnd_flags = FL_OF | FL_NX;
    end else if (e_q <= 10'sd0) begin
`ifdef FPU_DIV_DENORM_EN
      up        = dsig[1] & (dsig[0] | dst | dsig[2]);
      inexact   = dsig[1] | dsig[0] | dst;
      sum       = {7'd0, dsig[25:2]} + 31'(up);
      rnd_res   = {sign_q, sum};
      rnd_flags = inexact ? (FL_UF | FL_NX) : 5'b00000;
`else
      rnd_res   = {sign_q, 31'd0};
      rnd_flags = FL_UF | FL_NX;
`endif
    end else if (sum[30:23] == 8'hFF) begin
      rnd_res   = {sign_q, 8'hFF, 23'd0};
      rnd_flags = FL_OF | FL_NX;
    end
  end

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    e_d        = e_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    spec_res_d = spec_res_q;
    spec_fl_d  = spec_fl_q;
    valid_d    = valid_q;
    res_d      = res_q;
    flags_d    = flags_q;
    case (state_q)
      IDLE: begin
        if (valid_in && ready_out) begin
          sign_d     = sgn;
          ma_d       = a_man;
          mb_d       = b_man;
          e_d        = 10'({2'b00, ea_eff} - {2'b00, eb_eff} + 10'd127);
          spec_res_d = spec_val;
          spec_fl_d  = spec_fl;
          quo_d      = 26'd0;
          cnt_d      = 5'd0;
          state_d    = spec_hit ? SPECIAL : PRE;
        end
      end
      SPECIAL: begin
        res_d   = spec_res_q;
        flags_d = spec_fl_q;
        valid_d = 1'b1;
        state_d = DONE;
      end
      PRE: begin
`ifdef FPU_DIV_DENORM_EN
        if (!ma_q[23] || !mb_q[23]) begin
          if (!ma_q[23]) begin
            ma_d = ma_q << 1;
            e_d  = e_d - 10'sd1;
          end
          if (!mb_q[23]) begin
            mb_d = mb_q << 1;
            e_d  = e_d + 10'sd1;
          end
        end else
`endif
        begin
          if (ma_q < mb_q) begin
            rem_d = {1'b0, ma_q, 1'b0};
            e_d   = e_q - 10'sd1;
          end else begin
            rem_d = {2'b00, ma_q};
          end
          cnt_d   = 5'd0;
          state_d = ITER;
        end
      end
      ITER: begin
        if (rem_q >= {2'b00, mb_q}) begin
          quo_d = {quo_q[24:0], 1'b1};
          rem_d = (rem_q - {2'b00, mb_q}) << 1;
        end else begin
          quo_d = {quo_q[24:0], 1'b0};
          rem_d = rem_q << 1;
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(QBITS - 1)) state_d = ROUND;
      end
      ROUND: begin
        res_d   = rnd_res;
        flags_d = rnd_flags;
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (ready_in) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      e_q        <= '0;
      ma_q       <= '0;
      mb_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      spec_res_q <= '0;
      spec_fl_q  <= '0;
      valid_q    <= 1'b0;
      res_q      <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      e_q        <= e_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      spec_res_q <= spec_res_d;
      spec_fl_q  <= spec_fl_d;
      valid_q    <= valid_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
    end
  end
endmodule

// File: tb/tb_fpu_div_seq.sv
// Scoreboard bench for fpu_div_seq: directed corner cases plus random operands checked
// against an integer-division reference model.

module tb_fpu_div_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] a;
  logic [31:0] b;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] float_out;
  logic [4:0]  fflags;

  int          n_vec  = 0;
  int          n_fail = 0;
  longint      cyc    = 0;
  longint      hs_cyc = 0;
  logic [36:0] exp_q[$];

  fpu_div_seq dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .a(a), .b(b), .valid_out(valid_out), .ready_in(ready_in),
    .float_out(float_out), .fflags(fflags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic reportFail(input string name);
    n_vec++;
    n_fail++;
    $display("[TB] FAIL %s: got timeout, expected event", name);
  endtask

  // Reference: exact quotient from integer division of the significands, then RNE.
  function automatic logic [36:0] refDiv(input logic [31:0] x, input logic [31:0] y);
    bit s, x_nan, y_nan, x_snan, y_snan, x_inf, y_inf, x_zero, y_zero, inexact;
    int ex, ey, e, sh;
    longint unsigned mx, my, num, q, r, sig, rb, half;
    s      = x[31] ^ y[31];
    ex     = int'(x[30:23]);
    ey     = int'(y[30:23]);
    x_nan  = (ex == 255) && (x[22:0] != 0);
    y_nan  = (ey == 255) && (y[22:0] != 0);
    x_snan = x_nan && !x[22];
    y_snan = y_nan && !y[22];
    x_inf  = (ex == 255) && (x[22:0] == 0);
    y_inf  = (ey == 255) && (y[22:0] == 0);
    x_zero = (ex == 0);
    y_zero = (ey == 0);
    if (x_snan || y_snan) return {5'b10000, 32'h7FC00000};
    if (x_nan || y_nan) return {5'b00000, 32'h7FC00000};
    if ((x_inf && y_inf) || (x_zero && y_zero)) return {5'b10000, 32'h7FC00000};
    if (y_zero) return {5'b01000, s, 8'hFF, 23'd0};
    if (x_inf) return {5'b00000, s, 8'hFF, 23'd0};
    if (y_inf || x_zero) return {5'b00000, s, 31'd0};
    mx  = 64'h800000 | 64'(x[22:0]);
    my  = 64'h800000 | 64'(y[22:0]);
    num = mx << 40;
    q   = num / my;
    r   = num % my;
    e   = ex - ey + 127;
    if (q >= (64'd1 << 40)) sh = 17;
    else begin
      sh = 16;
      e  = e - 1;
    end
    sig     = q >> sh;
    rb      = q & ((64'd1 << sh) - 1);
    half    = 64'd1 << (sh - 1);
    inexact = (rb != 0) || (r != 0);
    if (e >= 255) return {5'b00101, s, 8'hFF, 23'd0};
    if (e <= 0) return {5'b00011, s, 31'd0};
    if ((rb > half) || ((rb == half) && ((r != 0) || sig[0]))) sig = sig + 1;
    if (sig == (64'd1 << 24)) begin
      sig = sig >> 1;
      e   = e + 1;
    end
    if (e >= 255) return {5'b00101, s, 8'hFF, 23'd0};
    return {4'b0000, inexact, s, e[7:0], sig[22:0]};
  endfunction

  task automatic applyStimulus(input logic [31:0] op_a, input logic [31:0] op_b, input logic [36:0] expv);
    int guard = 0;
    @(negedge clk);
    while (!ready_out && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!ready_out) begin
      reportFail("ready_out wait");
      return;
    end
    a        = op_a;
    b        = op_b;
    valid_in = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    hs_cyc   = cyc;
    valid_in = 1'b0;
  endtask

  task automatic waitResult(output int lat);
    int guard = 0;
    lat = 0;
    while (!valid_out && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!valid_out) reportFail("valid_out wait");
    else lat = int'(cyc - hs_cyc) + 1;
  endtask

  always @(negedge clk) begin
    logic [36:0] e37;
    if (!reset && valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("[TB] FAIL unexpected result: got %h/%b, expected none", float_out, fflags);
      end else begin
        e37 = exp_q.pop_front();
        checkOutput("result", {27'd0, fflags, float_out}, {27'd0, e37});
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int extra;
    logic [31:0] specials [8];
    logic [31:0] ra, rb;
    specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                 32'h7FC00001, 32'h7F800001, 32'h3F800000, 32'hC0600000};

    reset = 1'b1; valid_in = 1'b0; ready_in = 1'b1; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset valid_out", 64'(valid_out), 64'd0);
    checkOutput("reset float_out", 64'(float_out), 64'd0);
    checkOutput("reset fflags", 64'(fflags), 64'd0);
    checkOutput("reset ready_out", 64'(ready_out), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("ready after reset", 64'(ready_out), 64'd1);

    applyStimulus(32'h40C00000, 32'h40000000, {5'b00000, 32'h40400000});
    waitResult(lat);
    checkOutput("6/2 latency", 64'(lat), 64'd29);
    applyStimulus(32'h3F800000, 32'h40400000, {5'b00001, 32'h3EAAAAAB});
    waitResult(lat);
    applyStimulus(32'h7F7FFFFF, 32'h3F000000, {5'b00101, 32'h7F800000});
    waitResult(lat);
    applyStimulus(32'hBF800000, 32'h00000000, {5'b01000, 32'hFF800000});
    waitResult(lat);
    checkOutput("special latency<=3", 64'(lat <= 3), 64'd1);
    applyStimulus(32'h00000000, 32'h00000000, {5'b10000, 32'h7FC00000});
    waitResult(lat);
    applyStimulus(32'h7F800001, 32'h3F800000, {5'b10000, 32'h7FC00000});
    waitResult(lat);
`ifdef FPU_DIV_DENORM_EN
    applyStimulus(32'h00800000, 32'h40000000, {5'b00000, 32'h00400000});
`else
    applyStimulus(32'h00800000, 32'h40000000, {5'b00011, 32'h00000000});
`endif
    waitResult(lat);

    // Backpressure: result must sit unchanged while ready_in is low.
    @(negedge clk);
    @(negedge clk);
    ready_in = 1'b0;
    applyStimulus(32'h40C00000, 32'h40000000, {5'b00000, 32'h40400000});
    waitResult(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold float_out", 64'(float_out), 64'h40400000);
      checkOutput("hold fflags", 64'(fflags), 64'd0);
      checkOutput("hold ready_out", 64'(ready_out), 64'd0);
      checkOutput("hold valid_out", 64'(valid_out), 64'd1);
    end
    @(posedge clk);
    #1;
    ready_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("idle after release ready", 64'(ready_out), 64'd1);
    checkOutput("valid low after release", 64'(valid_out), 64'd0);

    // A valid_in pulse mid-iteration must be ignored.
    applyStimulus(32'h41200000, 32'h40A00000, {5'b00000, 32'h40000000});
    repeat (5) @(posedge clk);
    #1;
    a = 32'h3F800000; b = 32'h3F800000; valid_in = 1'b1;
    checkOutput("ready_out in ITER", 64'(ready_out), 64'd0);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    waitResult(lat);
    @(negedge clk);
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (valid_out) extra++;
    end
    checkOutput("no extra result", 64'(extra), 64'd0);

    // Reset during iteration discards the operation.
    applyStimulus(32'h40C00000, 32'h40000000, {5'b00000, 32'h40400000});
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    checkOutput("abort valid_out", 64'(valid_out), 64'd0);
    checkOutput("abort ready_out in reset", 64'(ready_out), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("abort ready_out", 64'(ready_out), 64'd1);
    applyStimulus(32'h40C00000, 32'h40000000, {5'b00000, 32'h40400000});
    waitResult(lat);
    checkOutput("6/2 after abort latency", 64'(lat), 64'd29);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) ra = specials[$urandom_range(0, 7)];
      else ra = {1'($urandom_range(0, 1)), 8'($urandom_range(70, 190)), 23'($urandom)};
      if ($urandom_range(0, 3) == 0) rb = specials[$urandom_range(0, 7)];
      else if ($urandom_range(0, 7) == 0) rb = {~ra[31], ra[30:0]};
      else rb = {1'($urandom_range(0, 1)), 8'($urandom_range(70, 190)), 23'($urandom)};
      applyStimulus(ra, rb, refDiv(ra, rb));
      waitResult(lat);
    end

    begin
      int guard = 0;
      while (exp_q.size() != 0 && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      if (exp_q.size() != 0) reportFail("scoreboard drain");
    end
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
